mips_ex_md: RTL and testbench

MIPS_EX_MD -- requirements
Module: mips_ex_md

---
 rtl/mips_ex_md.sv | 213 +++++++++++++++++++++
 tb/tb_mips_ex_md.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_ex_md.sv
// MIPS EX stage with HI/LO multiply/divide: single-cycle ALU/MFHI/MFLO pass-through,
// iterative radix-2 MULT/MULTU/DIV/DIVU taking DATA_WIDTH cycles in BUSY.
module mips_ex_md #(
  parameter int DATA_WIDTH  = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id2ex_valid,
  output logic                   ex2id_ready,
  input  logic                   flush,
  input  logic [2:0]             id2ex_md_op,
  input  logic [DATA_WIDTH-1:0]  id2ex_rs,
  input  logic [DATA_WIDTH-1:0]  id2ex_rt,
  input  logic [DATA_WIDTH-1:0]  id2ex_alu_res,
  input  logic [RFIDX_WIDTH-1:0] id2ex_rd_idx,
  input  logic                   id2ex_rd_wen,
  output logic                   ex2mem_valid,
  input  logic                   mem2ex_ready,
  output logic [RFIDX_WIDTH-1:0] ex2mem_rd_idx,
  output logic [DATA_WIDTH-1:0]  ex2mem_rd_wdat,
  output logic                   ex2mem_rd_wen,
  output logic                   ex2mem_md_busy
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MFHI  = 3'd5;
  localparam logic [2:0] OP_MFLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [W:0]       acc_q, acc_d;
  logic [W-1:0]     sh_q, sh_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic [W-1:0]     dvd_q, dvd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             valid_q, valid_d;
  logic [RFIDX_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [W-1:0]     wdat_q, wdat_d;
  logic             wen_q, wen_d;

  logic             accept;
  logic             op_signed;
  logic [W-1:0]     rs_mag, rt_mag;
  logic [W:0]       mul_sum, div_shift;
  logic             div_ge;
  logic [W:0]       acc_step;
  logic [W-1:0]     sh_step;
  logic [2*W-1:0]   prod, prod_s;
  logic [W-1:0]     quot_s, rem_s, fin_hi, fin_lo;

  assign ex2id_ready    = (state_q == IDLE) && (!valid_q || mem2ex_ready);
  assign ex2mem_md_busy = (state_q == BUSY);
  assign ex2mem_valid   = valid_q;
  assign ex2mem_rd_idx  = rd_idx_q;
  assign ex2mem_rd_wdat = wdat_q;
  assign ex2mem_rd_wen  = wen_q;

  assign accept    = id2ex_valid && ex2id_ready && !flush;
  assign op_signed = (id2ex_md_op == OP_MULT) || (id2ex_md_op == OP_DIV);
  assign rs_mag    = (op_signed && id2ex_rs[W-1]) ? -id2ex_rs : id2ex_rs;
  assign rt_mag    = (op_signed && id2ex_rt[W-1]) ? -id2ex_rt : id2ex_rt;

  // Both units run on magnitudes; signs are applied once at commit.
  assign mul_sum   = sh_q[0] ? (acc_q + {1'b0, opnd_q}) : acc_q;
  assign div_shift = {acc_q[W-1:0], sh_q[W-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});

  always_comb begin
    if (is_div_q) begin
      acc_step = div_ge ? (div_shift - {1'b0, opnd_q}) : div_shift;
      sh_step  = {sh_q[W-2:0], div_ge};
    end else begin
      acc_step = {1'b0, mul_sum[W:1]};
      sh_step  = {mul_sum[0], sh_q[W-1:1]};
    end
  end

  assign prod   = {acc_step[W-1:0], sh_step};
  assign prod_s = neg_q  ? -prod : prod;
  assign quot_s = neg_q  ? -sh_step : sh_step;
  assign rem_s  = rneg_q ? -acc_step[W-1:0] : acc_step[W-1:0];

  always_comb begin
    if (!is_div_q) begin
      fin_hi = prod_s[2*W-1:W];
      fin_lo = prod_s[W-1:0];
    end else if (dz_q) begin
      fin_hi = dvd_q;
      fin_lo = '1;
    end else begin
      fin_hi = rem_s;
      fin_lo = quot_s;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opnd_d   = opnd_q;
    dvd_d    = dvd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    valid_d  = valid_q;
    rd_idx_d = rd_idx_q;
    wdat_d   = wdat_q;
    wen_d    = wen_q;

    if (valid_q && mem2ex_ready) valid_d = 1'b0;

    if (flush) begin
      // Aborted op never reaches HI/LO.
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (state_q == BUSY) begin
      acc_d = acc_step;
      sh_d  = sh_step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(W - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        hi_d    = fin_hi;
        lo_d    = fin_lo;
      end
    end else if (accept) begin
      case (id2ex_md_op)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          state_d  = BUSY;
          cnt_d    = '0;
          is_div_d = (id2ex_md_op == OP_DIV) || (id2ex_md_op == OP_DIVU);
          acc_d    = '0;
          opnd_d   = is_div_d ? rt_mag : rs_mag;
          sh_d     = is_div_d ? rs_mag : rt_mag;
          dvd_d    = id2ex_rs;
          neg_d    = op_signed && (id2ex_rs[W-1] ^ id2ex_rt[W-1]);
          rneg_d   = op_signed && id2ex_rs[W-1];
          dz_d     = (id2ex_rt == '0);
          valid_d  = 1'b0;
        end
        OP_MFHI, OP_MFLO: begin
          valid_d  = 1'b1;
          rd_idx_d = id2ex_rd_idx;
          wen_d    = id2ex_rd_wen;
          wdat_d   = (id2ex_md_op == OP_MFHI) ? hi_q : lo_q;
        end
        default: begin
          valid_d  = 1'b1;
          rd_idx_d = id2ex_rd_idx;
          wen_d    = id2ex_rd_wen;
          wdat_d   = id2ex_alu_res;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      opnd_q   <= '0;
      dvd_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      valid_q  <= 1'b0;
      rd_idx_q <= '0;
      wdat_q   <= '0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opnd_q   <= opnd_d;
      dvd_q    <= dvd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      valid_q  <= valid_d;
      rd_idx_q <= rd_idx_d;
      wdat_q   <= wdat_d;
      wen_q    <= wen_d;
    end
  end

endmodule

// File: tb/tb_mips_ex_md.sv
// Directed bench for mips_ex_md: vector table for ALU/mul/div results read back
// through MFHI/MFLO, plus backpressure, flush and mid-operation reset sequences.
module tb_mips_ex_md;

  logic        clk = 1'b0;
  logic        rst;
  logic        id2ex_valid;
  logic        ex2id_ready;
  logic        flush;
  logic [2:0]  id2ex_md_op;
  logic [31:0] id2ex_rs, id2ex_rt, id2ex_alu_res;
  logic [4:0]  id2ex_rd_idx;
  logic        id2ex_rd_wen;
  logic        ex2mem_valid;
  logic        mem2ex_ready;
  logic [4:0]  ex2mem_rd_idx;
  logic [31:0] ex2mem_rd_wdat;
  logic        ex2mem_rd_wen;
  logic        ex2mem_md_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int xfer_cnt = 0;

  always #5 clk = ~clk;

  mips_ex_md #(.DATA_WIDTH(32), .RFIDX_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .id2ex_valid(id2ex_valid), .ex2id_ready(ex2id_ready),
    .flush(flush), .id2ex_md_op(id2ex_md_op), .id2ex_rs(id2ex_rs), .id2ex_rt(id2ex_rt),
    .id2ex_alu_res(id2ex_alu_res), .id2ex_rd_idx(id2ex_rd_idx), .id2ex_rd_wen(id2ex_rd_wen),
    .ex2mem_valid(ex2mem_valid), .mem2ex_ready(mem2ex_ready), .ex2mem_rd_idx(ex2mem_rd_idx),
    .ex2mem_rd_wdat(ex2mem_rd_wdat), .ex2mem_rd_wen(ex2mem_rd_wen),
    .ex2mem_md_busy(ex2mem_md_busy)
  );

  always @(posedge clk)
    if (!rst && ex2mem_valid && mem2ex_ready) xfer_cnt <= xfer_cnt + 1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] exp_a;   // wdat for NONE-class ops, HI for mul/div
    logic [31:0] exp_b;   // LO for mul/div
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [31:0] alu, input logic [4:0] rd);
    int n = 0;
    @(negedge clk);
    while (!ex2id_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", 64'd0, 64'd1);
    id2ex_md_op   = op;
    id2ex_rs      = rs;
    id2ex_rt      = rt;
    id2ex_alu_res = alu;
    id2ex_rd_idx  = rd;
    id2ex_rd_wen  = 1'b1;
    id2ex_valid   = 1'b1;
    @(posedge clk);
    #1 id2ex_valid = 1'b0;
  endtask

  task automatic busy_run(input string nm);
    int n = 0;
    int bad = 0;
    @(negedge clk);
    while (ex2mem_md_busy && n < 100) begin
      if (ex2id_ready) bad++;
      n++;
      @(negedge clk);
    end
    chk({nm, "_busy_len"}, 64'(n), 64'd32);
    chk({nm, "_ready_low"}, 64'(bad), 64'd0);
  endtask

  task automatic readhl(input string nm, input logic [31:0] eh, input logic [31:0] el);
    send(3'd5, 32'd0, 32'd0, 32'd0, 5'd3);
    @(negedge clk);
    chk({nm, "_mfhi_valid"}, 64'(ex2mem_valid), 64'd1);
    chk({nm, "_hi"}, 64'(ex2mem_rd_wdat), 64'(eh));
    send(3'd6, 32'd0, 32'd0, 32'd0, 5'd2);
    @(negedge clk);
    chk({nm, "_mflo_rd"}, 64'(ex2mem_rd_idx), 64'd2);
    chk({nm, "_lo"}, 64'(ex2mem_rd_wdat), 64'(el));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    vecs[0]  = '{3'd0, 32'h0,        32'h0,        32'h00001234, 5'd5, 32'h00001234, 32'h0};
    vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'h0,        5'd0, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        5'd0, 32'hFFFFFFFE, 32'h00000001};
    vecs[3]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'h0,        5'd0, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{3'd4, 32'h00000007, 32'h00000000, 32'h0,        5'd0, 32'h00000007, 32'hFFFFFFFF};
    vecs[5]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        5'd0, 32'h00000000, 32'h80000000};
    vecs[6]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h0,        5'd0, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{3'd4, 32'd100,      32'd7,        32'h0,        5'd0, 32'd2,        32'd14};
    vecs[8]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h0,        5'd0, 32'h40000000, 32'h00000000};
    vecs[9]  = '{3'd3, 32'hFFFFFFFB, 32'h00000000, 32'h0,        5'd0, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[10] = '{3'd2, 32'h12345678, 32'h00000010, 32'h0,        5'd0, 32'h00000001, 32'h23456780};
    vecs[11] = '{3'd7, 32'h0,        32'h0,        32'h0000DEAD, 5'd9, 32'h0000DEAD, 32'h0};

    rst = 1'b1; flush = 1'b0; id2ex_valid = 1'b0; mem2ex_ready = 1'b1;
    id2ex_md_op = 3'd0; id2ex_rs = '0; id2ex_rt = '0; id2ex_alu_res = '0;
    id2ex_rd_idx = '0; id2ex_rd_wen = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(ex2mem_valid), 64'd0);
    chk("rst_rd_idx", 64'(ex2mem_rd_idx), 64'd0);
    chk("rst_wdat", 64'(ex2mem_rd_wdat), 64'd0);
    chk("rst_wen", 64'(ex2mem_rd_wen), 64'd0);
    chk("rst_busy", 64'(ex2mem_md_busy), 64'd0);
    chk("rst_ready", 64'(ex2id_ready), 64'd1);
    readhl("rst", 32'h0, 32'h0);

    for (int i = 0; i < 12; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].alu, vecs[i].rd);
      if (vecs[i].op >= 3'd1 && vecs[i].op <= 3'd4) begin
        busy_run(nm);
        readhl(nm, vecs[i].exp_a, vecs[i].exp_b);
      end else begin
        @(negedge clk);
        chk({nm, "_valid"}, 64'(ex2mem_valid), 64'd1);
        chk({nm, "_rd_idx"}, 64'(ex2mem_rd_idx), 64'(vecs[i].rd));
        chk({nm, "_wen"}, 64'(ex2mem_rd_wen), 64'd1);
        chk({nm, "_wdat"}, 64'(ex2mem_rd_wdat), 64'(vecs[i].exp_a));
      end
    end

    // Backpressure: beat held three cycles, then exactly one transfer.
    @(negedge clk);
    mem2ex_ready = 1'b0;
    send(3'd0, 32'd0, 32'd0, 32'h0000AAAA, 5'd7);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(ex2mem_valid), 64'd1);
      chk("bp_wdat", 64'(ex2mem_rd_wdat), 64'h0000AAAA);
      chk("bp_rd_idx", 64'(ex2mem_rd_idx), 64'd7);
      chk("bp_ready", 64'(ex2id_ready), 64'd0);
    end
    x0 = xfer_cnt;
    mem2ex_ready = 1'b1;
    @(negedge clk);
    chk("bp_one_xfer", 64'(xfer_cnt - x0), 64'd1);
    chk("bp_valid_drop", 64'(ex2mem_valid), 64'd0);
    @(negedge clk);
    chk("bp_no_dup", 64'(xfer_cnt - x0), 64'd1);

    // Flush overrides a same-cycle accept.
    id2ex_md_op = 3'd0; id2ex_alu_res = 32'h5555; id2ex_rd_idx = 5'd4;
    id2ex_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 id2ex_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_valid", 64'(ex2mem_valid), 64'd0);

    // Flush at busy cycle 10 of a DIVU leaves HI=0x11, LO=0x22.
    send(3'd4, 32'h00002211, 32'h00000100, 32'd0, 5'd0);
    busy_run("preset");
    send(3'd4, 32'd1000, 32'd3, 32'd0, 5'd0);
    @(negedge clk);
    repeat (9) @(negedge clk);
    chk("flush_pre_busy", 64'(ex2mem_md_busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", 64'(ex2mem_md_busy), 64'd0);
    chk("flush_ready", 64'(ex2id_ready), 64'd1);
    chk("flush_valid", 64'(ex2mem_valid), 64'd0);
    readhl("flush", 32'h00000011, 32'h00000022);

    // Reset at busy cycle 5 of a MULT.
    send(3'd1, 32'd3, 32'd5, 32'd0, 5'd0);
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("rst5_pre_busy", 64'(ex2mem_md_busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst5_valid", 64'(ex2mem_valid), 64'd0);
    chk("rst5_rd_idx", 64'(ex2mem_rd_idx), 64'd0);
    chk("rst5_wdat", 64'(ex2mem_rd_wdat), 64'd0);
    chk("rst5_wen", 64'(ex2mem_rd_wen), 64'd0);
    chk("rst5_busy", 64'(ex2mem_md_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    readhl("rst5", 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
